ysyx_24090003_inst_enc: RTL and testbench
=========================================

Name: ysyx_24090003_inst_enc

Overview:
Instruction encoder: the inverse of the immediate decoder. Accepts decoded fields (type, opcode, funct3/7, rd/rs1/rs2, 32-bit signed immediate) and packs them into a 32-bit RV32I instruction word, with range checking. It feeds the difftest/trap-injection path and self-check benches that build instructions on the fly. Input and output use valid/ready handshakes, with a small output FIFO to absorb backpressure.

Parameters:
DEPTH, 2, output FIFO entries (power of 2, ≥2)
CNT_W, 16, width of saturating error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  encoder can accept
in_itype  in  3  000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110/111 illegal
in_opcode  in  7  inst[6:0]
in_funct3  in  3  inst[14:12]
in_funct7  in  7  inst[31:25] (R only)
in_rd  in  5  destination reg
in_rs1  in  5  source reg 1
in_rs2  in  5  source reg 2
in_imm  in  32  signed immediate, byte offset for B/J, full value for U
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts
out_inst  out  32  encoded instruction (0 when out_err)
out_err  out  1  request was unencodable
err_cnt  out  CNT_W  count of erroneous requests, saturates at all-ones

Behaviour:
- Clock and reset: one clock, clk. Reset (rst) is synchronous and active-high.
- Reset state: FIFO empty, out_valid=0, out_inst=0, out_err=0, err_cnt=0, in_ready=1 in the cycle after reset. Reset mid-operation discards all queued entries.
- Accept: a request is accepted on in_valid&in_ready. in_ready = !full. There is no full-cycle bypass: when full, in_ready=0 even if out_ready=1.
- Encode (combinational on accepted fields, written into the FIFO tail):
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - Fields not used by a type are ignored.
- Range check (see Optional Feature). An error occurs when any of these holds:
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094], or imm[0]=1.
  - J: imm outside [-2^20, 2^20-2], or imm[0]=1.
  - U: imm[11:0]≠0.
  - itype 110 or 111.
  - On error the entry stores inst=0 and err=1.
- Latency: an accepted request appears at the FIFO head 1 cycle later. out_valid = !empty. out_inst/out_err are driven from the head, registered.
- Dequeue on out_valid&out_ready. Enqueue and dequeue in the same cycle (not full) both occur and count is unchanged.
- FIFO pointers wrap modulo DEPTH. The count register is 0..DEPTH.
- err_cnt increments by 1 in the accept cycle of each erroneous request and holds at 2^CNT_W-1.
- out_inst/out_err are stable while out_valid&!out_ready.

Optional Feature:
Macro YSYX_24090003_INST_ENC_RANGE_CHK_EN.
- Defined: range and illegal-type checks as above.
- Undefined: no checks. Immediates are truncated to their field bits, itype 110/111 encode as R. out_err is tied to 0 and err_cnt is tied to 0.

Test Plan:
- I-type: itype=001, opcode=0x13, f3=0, rd=1, rs1=0, imm=5 → 1 cycle later out_valid=1, out_inst=0x00500093, out_err=0.
- S-type and B-type back-to-back with out_ready=1:
  - S: opcode=0x23, f3=2, rs1=1, rs2=2, imm=8 → 0x0020A423.
  - B: opcode=0x63, f3=0, rs1=rs2=0, imm=-4 → 0xFE000EE3.
  - Both appear on consecutive cycles.
- U and J:
  - U: opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7.
  - J: opcode=0x6F, rd=0, imm=-8 → 0xFF9FF06F.
- Errors (macro defined):
  - I-type imm=2048 → out_inst=0, out_err=1, err_cnt=1.
  - B-type imm=3 → err_cnt=2.
  - itype=111 → err_cnt=3.
  - Macro undefined: I-type imm=2048 → 0x80000093-style truncation (imm[11:0]=0x800), out_err=0.
- Backpressure: out_ready=0, drive 3 valid requests → first two accepted, in_ready=0 from the cycle after the 2nd accept, third held. Raise out_ready → entries drain in order, third accepted.
- Reset mid-stream: with FIFO full, assert rst 1 cycle → next cycle out_valid=0, err_cnt=0, in_ready=1. The queued words are never output.

Source files
------------

// File: rtl/ysyx_24090003_inst_enc.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, queued in a small output FIFO.
// Define YSYX_24090003_INST_ENC_RANGE_CHK_EN to enable immediate range / illegal-type checking.
module ysyx_24090003_inst_enc #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_itype,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        TYPE_R = 3'b000,
        TYPE_I = 3'b001,
        TYPE_S = 3'b010,
        TYPE_B = 3'b011,
        TYPE_U = 3'b100,
        TYPE_J = 3'b101
    } itype_e;

    logic [31:0]    encInst;
    logic [31:0]    entryInst;
    logic           entryErr;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic [31:0]    memInst [DEPTH];
    logic           memErr  [DEPTH];

    // Illegal types fall through to the R layout; with checking enabled the error masks them.
    always_comb begin
        case (itype_e'(in_itype))
            TYPE_I:  encInst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            TYPE_S:  encInst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            TYPE_B:  encInst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_opcode};
            TYPE_U:  encInst = {in_imm[31:12], in_rd, in_opcode};
            TYPE_J:  encInst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            default: encInst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        endcase
    end

`ifdef YSYX_24090003_INST_ENC_RANGE_CHK_EN
    logic signed [31:0] immS;
    logic               rangeErr;
    logic [CNT_W-1:0]   errCnt;

    assign immS = $signed(in_imm);

    // NOTE: rangeErr is assigned a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rangeErr = 1'b0;
        case (in_itype)
            3'b001, 3'b010: rangeErr = (immS < -32'sd2048) || (immS > 32'sd2047);
            3'b011:         rangeErr = (immS < -32'sd4096) || (immS > 32'sd4094) || in_imm[0];
            3'b100:         rangeErr = (in_imm[11:0] != 12'd0);
            3'b101:         rangeErr = (immS < -32'sd1048576) || (immS > 32'sd1048574) || in_imm[0];
            3'b110, 3'b111: rangeErr = 1'b1;
            default:        rangeErr = 1'b0;
        endcase
    end

    assign entryErr  = rangeErr;
    assign entryInst = rangeErr ? 32'd0 : encInst;

    always_ff @(posedge clk) begin
        if (rst) begin
            errCnt <= '0;
        end else if (push && rangeErr && (errCnt != {CNT_W{1'b1}})) begin
            errCnt <= errCnt + 1'b1;
        end
    end

    assign err_cnt = errCnt;
    assign out_err = empty ? 1'b0 : memErr[rdPtr];
`else
    assign entryErr  = 1'b0;
    assign entryInst = encInst;
    assign err_cnt   = '0;
    assign out_err   = 1'b0;
`endif

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop      = out_valid && out_ready;

    // Pointers and count are state; the storage array carries no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; empty masks stale contents at the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            memInst[wrPtr] <= entryInst;
            memErr[wrPtr]  <= entryErr;
        end
    end

    assign out_inst = empty ? 32'd0 : memInst[rdPtr];

endmodule

// File: tb/tb_ysyx_24090003_inst_enc.sv
// Directed self-checking bench for ysyx_24090003_inst_enc (default DEPTH=2, CNT_W=16).
module tb_ysyx_24090003_inst_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_itype;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] err_cnt;

    int nChecks = 0;
    int nFails  = 0;

    ysyx_24090003_inst_enc dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_itype(in_itype), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        in_itype = t; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_req(3'b000, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        nChecks++; if (out_inst !== 32'd0) begin nFails++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
        nChecks++; if (out_err !== 1'b0) begin nFails++; $display("FAIL reset_out_err: got %b want 0", out_err); end
        nChecks++; if (err_cnt !== 16'd0) begin nFails++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_itype();
        out_ready = 1'b1;
        set_req(3'b001, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        in_valid = 1'b0;
        nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("FAIL itype_valid: got %b want 1", out_valid); end
        nChecks++; if (out_inst !== 32'h00500093) begin nFails++; $display("FAIL itype_inst: got %h want 00500093", out_inst); end
        nChecks++; if (out_err !== 1'b0) begin nFails++; $display("FAIL itype_err: got %b want 0", out_err); end
        tick();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL itype_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        set_req(3'b010, 7'h23, 3'd2, 7'h0, 5'd0, 5'd1, 5'd2, 32'd8);
        tick();
        set_req(3'b011, 7'h63, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, -32'sd4);
        nChecks++; if (out_inst !== 32'h0020A423) begin nFails++; $display("FAIL stype_inst: got %h want 0020A423", out_inst); end
        tick();
        in_valid = 1'b0;
        nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("FAIL btype_valid: got %b want 1", out_valid); end
        nChecks++; if (out_inst !== 32'hFE000EE3) begin nFails++; $display("FAIL btype_inst: got %h want FE000EE3", out_inst); end
        tick();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_u_j();
        out_ready = 1'b1;
        set_req(3'b100, 7'h37, 3'd0, 7'h0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        tick();
        set_req(3'b101, 7'h6F, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, -32'sd8);
        nChecks++; if (out_inst !== 32'h123452B7) begin nFails++; $display("FAIL utype_inst: got %h want 123452B7", out_inst); end
        tick();
        in_valid = 1'b0;
        nChecks++; if (out_inst !== 32'hFF9FF06F) begin nFails++; $display("FAIL jtype_inst: got %h want FF9FF06F", out_inst); end
        tick();
    endtask

    // Legal extremes of the I range encode identically with or without checking.
    task automatic test_boundaries();
        out_ready = 1'b1;
        set_req(3'b001, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2047);
        tick();
        set_req(3'b001, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, -32'sd2048);
        nChecks++; if (out_inst !== 32'h7FF00093) begin nFails++; $display("FAIL imm_max_inst: got %h want 7FF00093", out_inst); end
        tick();
        set_req(3'b011, 7'h63, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd4094);
        nChecks++; if (out_inst !== 32'h80000093) begin nFails++; $display("FAIL imm_min_inst: got %h want 80000093", out_inst); end
        tick();
        in_valid = 1'b0;
        nChecks++; if (out_inst !== 32'h7E000FE3) begin nFails++; $display("FAIL bmax_inst: got %h want 7E000FE3", out_inst); end
        nChecks++; if (out_err !== 1'b0) begin nFails++; $display("FAIL bmax_err: got %b want 0", out_err); end
        tick();
    endtask

`ifdef YSYX_24090003_INST_ENC_RANGE_CHK_EN
    task automatic test_errors();
        out_ready = 1'b1;
        set_req(3'b001, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        set_req(3'b011, 7'h63, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd3);
        nChecks++; if (out_inst !== 32'd0) begin nFails++; $display("FAIL err_i_inst: got %h want 0", out_inst); end
        nChecks++; if (out_err !== 1'b1) begin nFails++; $display("FAIL err_i_flag: got %b want 1", out_err); end
        nChecks++; if (err_cnt !== 16'd1) begin nFails++; $display("FAIL err_i_cnt: got %0d want 1", err_cnt); end
        tick();
        set_req(3'b111, 7'h33, 3'd0, 7'h0, 5'd1, 5'd2, 5'd3, 32'd0);
        nChecks++; if (err_cnt !== 16'd2) begin nFails++; $display("FAIL err_b_cnt: got %0d want 2", err_cnt); end
        nChecks++; if (out_err !== 1'b1) begin nFails++; $display("FAIL err_b_flag: got %b want 1", out_err); end
        tick();
        set_req(3'b011, 7'h63, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd4096);
        nChecks++; if (err_cnt !== 16'd3) begin nFails++; $display("FAIL err_type_cnt: got %0d want 3", err_cnt); end
        nChecks++; if (out_inst !== 32'd0) begin nFails++; $display("FAIL err_type_inst: got %h want 0", out_inst); end
        tick();
        set_req(3'b101, 7'h6F, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, -32'sd1048576);
        nChecks++; if (err_cnt !== 16'd4) begin nFails++; $display("FAIL err_bover_cnt: got %0d want 4", err_cnt); end
        tick();
        in_valid = 1'b0;
        nChecks++; if (out_err !== 1'b0) begin nFails++; $display("FAIL jmin_err: got %b want 0", out_err); end
        nChecks++; if (out_inst !== 32'h8000006F) begin nFails++; $display("FAIL jmin_inst: got %h want 8000006F", out_inst); end
        nChecks++; if (err_cnt !== 16'd4) begin nFails++; $display("FAIL jmin_cnt: got %0d want 4", err_cnt); end
        tick();
    endtask
`else
    task automatic test_errors();
        out_ready = 1'b1;
        set_req(3'b001, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        set_req(3'b111, 7'h33, 3'd5, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0);
        nChecks++; if (out_inst !== 32'h80000093) begin nFails++; $display("FAIL trunc_i_inst: got %h want 80000093", out_inst); end
        nChecks++; if (out_err !== 1'b0) begin nFails++; $display("FAIL trunc_i_err: got %b want 0", out_err); end
        tick();
        in_valid = 1'b0;
        nChecks++; if (out_inst !== 32'h403150B3) begin nFails++; $display("FAIL illegal_as_r: got %h want 403150B3", out_inst); end
        nChecks++; if (err_cnt !== 16'd0) begin nFails++; $display("FAIL nochk_cnt: got %0d want 0", err_cnt); end
        tick();
    endtask
`endif

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_req(3'b001, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd1);
        tick();
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL bp_ready_one: got %b want 1", in_ready); end
        set_req(3'b001, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2);
        tick();
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
        nChecks++; if (out_inst !== 32'h00100093) begin nFails++; $display("FAIL bp_head_a: got %h want 00100093", out_inst); end
        set_req(3'b001, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd3);
        tick();
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL bp_still_full: got %b want 0", in_ready); end
        nChecks++; if (out_inst !== 32'h00100093) begin nFails++; $display("FAIL bp_stable: got %h want 00100093", out_inst); end
        out_ready = 1'b1;
        tick();
        nChecks++; if (out_inst !== 32'h00200093) begin nFails++; $display("FAIL bp_head_b: got %h want 00200093", out_inst); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL bp_ready_again: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        nChecks++; if (out_inst !== 32'h00300093) begin nFails++; $display("FAIL bp_head_c: got %h want 00300093", out_inst); end
        tick();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_req(3'b111, 7'h33, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd0);
        tick();
        set_req(3'b001, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd9);
        tick();
        in_valid = 1'b0;
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL mid_full: got %b want 0", in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        nChecks++; if (err_cnt !== 16'd0) begin nFails++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL mid_ready: got %b want 1", in_ready); end
        tick();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL mid_no_stale: got %b want 0", out_valid); end
        nChecks++; if (out_inst !== 32'd0) begin nFails++; $display("FAIL mid_inst: got %h want 0", out_inst); end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_back_to_back();
        test_u_j();
        test_boundaries();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
